// File: rtl/capture_ctrl_pkg.sv
// Shared types and defaults for the logIP capture path.
package logIP_pkg;

   localparam int CAPTURE_CNTW_DEFAULT  = 16;
   localparam int CAPTURE_WIDTH_DEFAULT = 32;
   localparam int CAPTURE_DEPTH_DEFAULT = 5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARMED = 3'd1,
      ST_DELAY = 3'd2,
      ST_ALIGN = 3'd3,
      ST_READ  = 3'd4,
      ST_WAIT  = 3'd5,
      ST_SEND  = 3'd6
   } capture_state_t;

endpackage

// File: rtl/capture_ctrl_if.sv
// Sample RAM bus and transmitter handshake of the capture controller.
interface capture_ctrl_if #(
   parameter int WIDTH = logIP_pkg::CAPTURE_WIDTH_DEFAULT
);
   logic             mem_wrt_o;
   logic             mem_read_o;
   logic [WIDTH-1:0] mem_o;
   logic [WIDTH-1:0] mem_i;
   logic [WIDTH-1:0] tx_data_o;
   logic             tx_vld_o;
   logic             tx_rdy_i;

   modport master (
      output mem_wrt_o, mem_read_o, mem_o, tx_data_o, tx_vld_o,
      input  mem_i, tx_rdy_i
   );

   modport slave (
      input  mem_wrt_o, mem_read_o, mem_o, tx_data_o, tx_vld_o,
      output mem_i, tx_rdy_i
   );
endinterface

// File: rtl/capture_ctrl_cnt.sv
// Loadable down-counter with zero flag; used for the delay and read counts.
module capture_cnt
   import logIP_pkg::*;
#(
   parameter int CNTW = CAPTURE_CNTW_DEFAULT
) (
   input  logic            clk_i,
   input  logic            rst_in,
   input  logic            load_i,
   input  logic [CNTW-1:0] load_val_i,
   input  logic            dec_i,
   output logic [CNTW-1:0] cnt_o,
   output logic            zero_o
);

   logic [CNTW-1:0] r_cnt;

   // load has priority; decrement stops at zero
   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         r_cnt <= '0;
      end else if (load_i) begin
         r_cnt <= load_val_i;
      end else if (dec_i && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign cnt_o  = r_cnt;
   assign zero_o = (r_cnt == '0);

endmodule

// File: rtl/capture_ctrl.sv
// Capture controller: writes samples into the ring RAM, waits out the
// post-trigger delay, then reads the capture back newest-first.
//
// state | meaning
// IDLE  | waiting for run_i, counts latched on run_i
// ARMED | writing every sample, watching for a qualified trigger
// DELAY | writing post-trigger samples until the delay count expires
// ALIGN | let the last write land, one discarded read, wait out its data
// READ  | read strobe for the next sample
// WAIT  | RAM data arrives, captured into the transmit register
// SEND  | hold tx data until the transmitter accepts it
module capture_ctrl
   import logIP_pkg::*;
#(
   parameter int WIDTH = CAPTURE_WIDTH_DEFAULT,
   parameter int DEPTH = CAPTURE_DEPTH_DEFAULT,
   parameter int CNTW  = CAPTURE_CNTW_DEFAULT
) (
   input  logic             clk_i,
   input  logic             rst_in,
   input  logic             run_i,
   input  logic             abort_i,
   input  logic [WIDTH-1:0] smpl_i,
   input  logic             smpl_vld_i,
   input  logic             trg_i,
   input  logic [CNTW-1:0]  read_cnt_i,
   input  logic [CNTW-1:0]  delay_cnt_i,
   capture_ctrl_if.master   bus,
   output logic             busy_o,
   output logic             done_o
);

   // reading more than the ring holds would only return overwritten data
   localparam logic [CNTW-1:0] RD_MAX = CNTW'(2**DEPTH);

   capture_state_t   r_state;
   logic [1:0]       r_aln_ph;
   logic             r_mem_wrt;
   logic             r_mem_read;
   logic [WIDTH-1:0] r_mem_data;
   logic [WIDTH-1:0] r_tx_data;
   logic             r_tx_vld;
   logic             r_busy;
   logic             r_done;

   logic            w_start;
   logic            w_dly_dec;
   logic            w_rd_dec;
   logic [CNTW-1:0] w_rd_load_val;
   logic [CNTW-1:0] w_dly_cnt;
   logic [CNTW-1:0] w_rd_cnt;
   logic            w_dly_zero;
   logic            w_rd_zero;
   logic            w_dly_last;
   logic            w_rd_last;

   assign w_start       = (r_state == ST_IDLE) && run_i && !abort_i;
   assign w_dly_dec     = (r_state == ST_DELAY) && smpl_vld_i && !abort_i;
   assign w_rd_dec      = (r_state == ST_SEND) && bus.tx_rdy_i && !abort_i;
   assign w_rd_load_val = (read_cnt_i > RD_MAX) ? RD_MAX : read_cnt_i;
   assign w_dly_last    = (w_dly_cnt == CNTW'(1));
   assign w_rd_last     = (w_rd_cnt == CNTW'(1));

   capture_cnt #(.CNTW(CNTW)) u_dly_cnt (
      .clk_i      (clk_i),
      .rst_in     (rst_in),
      .load_i     (w_start),
      .load_val_i (delay_cnt_i),
      .dec_i      (w_dly_dec),
      .cnt_o      (w_dly_cnt),
      .zero_o     (w_dly_zero)
   );

   capture_cnt #(.CNTW(CNTW)) u_rd_cnt (
      .clk_i      (clk_i),
      .rst_in     (rst_in),
      .load_i     (w_start),
      .load_val_i (w_rd_load_val),
      .dec_i      (w_rd_dec),
      .cnt_o      (w_rd_cnt),
      .zero_o     (w_rd_zero)
   );

   // FSM with all outputs registered; strobes default low every cycle
   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         r_state    <= ST_IDLE;
         r_aln_ph   <= 2'd0;
         r_mem_wrt  <= 1'b0;
         r_mem_read <= 1'b0;
         r_mem_data <= '0;
         r_tx_data  <= '0;
         r_tx_vld   <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_mem_wrt  <= 1'b0;
         r_mem_read <= 1'b0;
         r_done     <= 1'b0;
         if (abort_i) begin
            r_state  <= ST_IDLE;
            r_aln_ph <= 2'd0;
            r_tx_vld <= 1'b0;
            r_busy   <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (run_i) begin
                     r_state <= ST_ARMED;
                     r_busy  <= 1'b1;
                  end
               end
               ST_ARMED: begin
                  if (smpl_vld_i) begin
                     r_mem_wrt  <= 1'b1;
                     r_mem_data <= smpl_i;
                     if (trg_i) begin
                        r_state  <= w_dly_zero ? ST_ALIGN : ST_DELAY;
                        r_aln_ph <= 2'd0;
                     end
                  end
               end
               ST_DELAY: begin
                  if (smpl_vld_i) begin
                     r_mem_wrt  <= 1'b1;
                     r_mem_data <= smpl_i;
                     if (w_dly_last) begin
                        r_state  <= ST_ALIGN;
                        r_aln_ph <= 2'd0;
                     end
                  end
               end
               ST_ALIGN: begin
                  // phase 0: final write lands, 1: discard read, 2: its data
                  case (r_aln_ph)
                     2'd0: begin
                        r_mem_read <= 1'b1;
                        r_aln_ph   <= 2'd1;
                     end
                     2'd1: begin
                        r_aln_ph <= 2'd2;
                     end
                     default: begin
                        r_aln_ph <= 2'd0;
                        if (w_rd_zero) begin
                           r_state <= ST_IDLE;
                           r_done  <= 1'b1;
                           r_busy  <= 1'b0;
                        end else begin
                           r_state    <= ST_READ;
                           r_mem_read <= 1'b1;
                        end
                     end
                  endcase
               end
               ST_READ: begin
                  r_state <= ST_WAIT;
               end
               ST_WAIT: begin
                  r_tx_data <= bus.mem_i;
                  r_tx_vld  <= 1'b1;
                  r_state   <= ST_SEND;
               end
               ST_SEND: begin
                  if (bus.tx_rdy_i) begin
                     r_tx_vld <= 1'b0;
                     if (w_rd_last) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                     end else begin
                        r_state    <= ST_READ;
                        r_mem_read <= 1'b1;
                     end
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.mem_wrt_o  = r_mem_wrt;
   assign bus.mem_read_o = r_mem_read;
   assign bus.mem_o      = r_mem_data;
   assign bus.tx_data_o  = r_tx_data;
   assign bus.tx_vld_o   = r_tx_vld;
   assign busy_o         = r_busy;
   assign done_o         = r_done;

endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl with a behavioural ring RAM and a capture model.
module tb_capture_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run_i;
   logic        abort_i;
   logic [31:0] smpl_i;
   logic        smpl_vld_i;
   logic        trg_i;
   logic [15:0] read_cnt_i;
   logic [15:0] delay_cnt_i;
   logic        busy_o;
   logic        done_o;

   int checks = 0;
   int errors = 0;

   capture_ctrl_if #(.WIDTH(32)) bus ();

   capture_ctrl #(.WIDTH(32), .DEPTH(5), .CNTW(16)) dut (
      .clk_i       (clk),
      .rst_in      (rst_n),
      .run_i       (run_i),
      .abort_i     (abort_i),
      .smpl_i      (smpl_i),
      .smpl_vld_i  (smpl_vld_i),
      .trg_i       (trg_i),
      .read_cnt_i  (read_cnt_i),
      .delay_cnt_i (delay_cnt_i),
      .bus         (bus),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   always #5 clk = ~clk;

   // ring RAM: write at pointer then increment, read at pointer then decrement
   logic [31:0] mmu_mem [32];
   logic [4:0]  mmu_ptr;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mmu_ptr   <= 5'd0;
         bus.mem_i <= 32'd0;
      end else if (bus.mem_wrt_o) begin
         mmu_mem[mmu_ptr] <= bus.mem_o;
         mmu_ptr          <= mmu_ptr + 5'd1;
      end else if (bus.mem_read_o) begin
         bus.mem_i <= mmu_mem[mmu_ptr];
         mmu_ptr   <= mmu_ptr - 5'd1;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // observed traffic, sampled mid-cycle
   logic [31:0] wr_q [$];
   logic [31:0] tx_q [$];
   int rd_cnt = 0;
   int done_cnt = 0;
   int overlap = 0;
   int last_wr_cyc = 0;
   int done_cyc = 0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.mem_wrt_o) begin
            wr_q.push_back(bus.mem_o);
            last_wr_cyc <= cyc;
         end
         if (bus.mem_read_o) rd_cnt <= rd_cnt + 1;
         if (bus.mem_wrt_o && bus.mem_read_o) overlap <= overlap + 1;
         if (done_o) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
         end
         if (bus.tx_vld_o && bus.tx_rdy_i) tx_q.push_back(bus.tx_data_o);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.mem_wrt_o !== 1'b0) begin errors++; $display("FAIL reset_mem_wrt got %b want 0", bus.mem_wrt_o); end
      checks++; if (bus.mem_read_o !== 1'b0) begin errors++; $display("FAIL reset_mem_read got %b want 0", bus.mem_read_o); end
      checks++; if (bus.mem_o !== 32'd0) begin errors++; $display("FAIL reset_mem_o got %h want 0", bus.mem_o); end
      checks++; if (bus.tx_data_o !== 32'd0) begin errors++; $display("FAIL reset_tx_data got %h want 0", bus.tx_data_o); end
      checks++; if (bus.tx_vld_o !== 1'b0) begin errors++; $display("FAIL reset_tx_vld got %b want 0", bus.tx_vld_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_o); end
      rst_n = 1'b1;
      tick();
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_release_busy got %b want 0", busy_o); end
   endtask

   // drive one full capture and compare against the expected write/readback
   task automatic do_capture(input string name, input int pre, input int dly,
                             input int rd, input bit rnd, input bit stall);
      logic [31:0] vals [$];
      logic [31:0] hold;
      int total, n, idx, cycles, rd_hold;
      int wr_base, tx_base, rd_base, done_base, ovl_base;
      bit stalled;
      total = pre + 1 + dly;
      n = (rd > 32) ? 32 : rd;
      for (int i = 0; i < total; i++) vals.push_back(rnd ? $urandom : 32'(i + 1));
      wr_base = wr_q.size(); tx_base = tx_q.size();
      rd_base = rd_cnt; done_base = done_cnt; ovl_base = overlap;
      read_cnt_i = 16'(rd); delay_cnt_i = 16'(dly);
      run_i = 1'b1;
      tick();
      run_i = 1'b0;
      read_cnt_i = 16'($urandom); delay_cnt_i = 16'($urandom);
      idx = 0; cycles = 0; stalled = 1'b0;
      while (done_cnt == done_base && cycles < 3000) begin
         if (stall && !stalled && bus.tx_vld_o) begin
            hold = bus.tx_data_o; rd_hold = rd_cnt;
            bus.tx_rdy_i = 1'b0;
            for (int k = 0; k < 10; k++) begin
               tick();
               checks++;
               if (bus.tx_vld_o !== 1'b1 || bus.tx_data_o !== hold) begin
                  errors++;
                  $display("FAIL %s stall_hold cyc %0d: vld=%b data=%h, want vld=1 data=%h", name, k, bus.tx_vld_o, bus.tx_data_o, hold);
               end
            end
            checks++;
            if (rd_cnt !== rd_hold) begin errors++; $display("FAIL %s stall_reads got %0d want %0d", name, rd_cnt - rd_base, rd_hold - rd_base); end
            stalled = 1'b1;
         end
         smpl_vld_i = 1'b0; trg_i = 1'b0; smpl_i = $urandom; run_i = 1'b0;
         if (idx < total) begin
            if (!rnd || $urandom_range(0, 3) != 0) begin
               smpl_vld_i = 1'b1;
               smpl_i = vals[idx];
               trg_i = (idx == pre) || (rnd && idx > pre && $urandom_range(0, 1) == 1);
               idx++;
            end else begin
               trg_i = 1'($urandom_range(0, 1));
            end
            if (rnd && idx > 0 && $urandom_range(0, 7) == 0) run_i = 1'b1;
         end else begin
            smpl_vld_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            trg_i = 1'($urandom_range(0, 1));
         end
         bus.tx_rdy_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
         cycles++;
      end
      smpl_vld_i = 1'b0; trg_i = 1'b0; run_i = 1'b0; bus.tx_rdy_i = 1'b0;
      checks++;
      if (done_cnt == done_base) begin errors++; $display("FAIL %s timeout no done after %0d cycles", name, cycles); end
      repeat (3) tick();
      checks++;
      if (done_cnt - done_base !== 1) begin errors++; $display("FAIL %s done_count got %0d want 1", name, done_cnt - done_base); end
      checks++;
      if (busy_o !== 1'b0) begin errors++; $display("FAIL %s busy_after got %b want 0", name, busy_o); end
      checks++;
      if (wr_q.size() - wr_base !== total) begin
         errors++; $display("FAIL %s write_count got %0d want %0d", name, wr_q.size() - wr_base, total);
      end else begin
         for (int i = 0; i < total; i++) begin
            checks++;
            if (wr_q[wr_base + i] !== vals[i]) begin errors++; $display("FAIL %s write[%0d] got %h want %h", name, i, wr_q[wr_base + i], vals[i]); end
         end
      end
      checks++;
      if (tx_q.size() - tx_base !== n) begin
         errors++; $display("FAIL %s tx_count got %0d want %0d", name, tx_q.size() - tx_base, n);
      end else begin
         for (int i = 0; i < n; i++) begin
            checks++;
            if (tx_q[tx_base + i] !== vals[total - 1 - i]) begin errors++; $display("FAIL %s tx[%0d] got %h want %h", name, i, tx_q[tx_base + i], vals[total - 1 - i]); end
         end
      end
      checks++;
      if (rd_cnt - rd_base !== n + 1) begin errors++; $display("FAIL %s read_strobes got %0d want %0d", name, rd_cnt - rd_base, n + 1); end
      checks++;
      if (overlap - ovl_base !== 0) begin errors++; $display("FAIL %s wrt_read_overlap got %0d want 0", name, overlap - ovl_base); end
      if (rd == 0) begin
         checks++;
         if (done_cyc - last_wr_cyc !== 3) begin errors++; $display("FAIL %s done_latency got %0d want 3", name, done_cyc - last_wr_cyc); end
      end
   endtask

   task automatic test_basic();   do_capture("basic", 4, 2, 4, 1'b0, 1'b0);   endtask
   task automatic test_zero();    do_capture("zero", 0, 0, 0, 1'b0, 1'b0);    endtask
   task automatic test_clamp();   do_capture("clamp", 40, 0, 40, 1'b0, 1'b0); endtask
   task automatic test_stall();   do_capture("stall", 5, 1, 3, 1'b0, 1'b1);   endtask

   task automatic test_abort();
      int wr_base, rd_base, done_base;
      wr_base = wr_q.size(); rd_base = rd_cnt; done_base = done_cnt;
      read_cnt_i = 16'd4; delay_cnt_i = 16'd5;
      run_i = 1'b1;
      tick();
      run_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         smpl_vld_i = 1'b1; smpl_i = 32'(100 + i); trg_i = (i == 2);
         tick();
      end
      smpl_vld_i = 1'b0; trg_i = 1'b0;
      abort_i = 1'b1; run_i = 1'b1;
      tick();
      abort_i = 1'b0; run_i = 1'b0;
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy_o); end
      checks++; if (bus.mem_wrt_o !== 1'b0) begin errors++; $display("FAIL abort_mem_wrt got %b want 0", bus.mem_wrt_o); end
      checks++; if (bus.mem_read_o !== 1'b0 || bus.tx_vld_o !== 1'b0) begin errors++; $display("FAIL abort_strobes got read=%b vld=%b want 0 0", bus.mem_read_o, bus.tx_vld_o); end
      for (int i = 0; i < 6; i++) begin
         smpl_vld_i = 1'b1; trg_i = 1'b1; smpl_i = $urandom;
         tick();
      end
      smpl_vld_i = 1'b0; trg_i = 1'b0;
      tick();
      checks++; if (wr_q.size() - wr_base !== 4) begin errors++; $display("FAIL abort_writes got %0d want 4", wr_q.size() - wr_base); end
      checks++; if (rd_cnt !== rd_base) begin errors++; $display("FAIL abort_reads got %0d want 0", rd_cnt - rd_base); end
      checks++; if (done_cnt !== done_base) begin errors++; $display("FAIL abort_done got %0d want 0", done_cnt - done_base); end
      do_capture("rearm", 3, 2, 5, 1'b0, 1'b0);
   endtask

   task automatic test_reset_send();
      int wr_base, wait_cyc;
      read_cnt_i = 16'd3; delay_cnt_i = 16'd1; bus.tx_rdy_i = 1'b0;
      run_i = 1'b1;
      tick();
      run_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         smpl_vld_i = 1'b1; smpl_i = 32'(200 + i); trg_i = (i == 3);
         tick();
      end
      smpl_vld_i = 1'b0; trg_i = 1'b0;
      wait_cyc = 0;
      while (bus.tx_vld_o !== 1'b1 && wait_cyc < 30) begin tick(); wait_cyc++; end
      checks++; if (bus.tx_vld_o !== 1'b1) begin errors++; $display("FAIL rst_send_reach got vld=%b want 1", bus.tx_vld_o); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.mem_wrt_o, bus.mem_read_o, bus.tx_vld_o, busy_o, done_o, bus.mem_o, bus.tx_data_o} !== '0) begin
         errors++;
         $display("FAIL rst_send_async got wrt=%b rd=%b vld=%b busy=%b done=%b mem_o=%h tx=%h want all 0",
                  bus.mem_wrt_o, bus.mem_read_o, bus.tx_vld_o, busy_o, done_o, bus.mem_o, bus.tx_data_o);
      end
      tick(); tick();
      rst_n = 1'b1;
      tick();
      wr_base = wr_q.size();
      for (int i = 0; i < 3; i++) begin
         smpl_vld_i = 1'b1; trg_i = 1'b1; smpl_i = $urandom;
         tick();
      end
      smpl_vld_i = 1'b0; trg_i = 1'b0;
      tick();
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_send_idle_busy got %b want 0", busy_o); end
      checks++; if (wr_q.size() !== wr_base) begin errors++; $display("FAIL rst_send_idle_writes got %0d want 0", wr_q.size() - wr_base); end
   endtask

   task automatic test_random();
      int pre, dly, rd, n;
      for (int it = 0; it < 6; it++) begin
         rd  = $urandom_range(0, 40);
         n   = (rd > 32) ? 32 : rd;
         dly = $urandom_range(0, 4);
         pre = $urandom_range(0, 8);
         if (pre + 1 + dly < n) pre = n - 1 - dly + $urandom_range(0, 3);
         do_capture($sformatf("rand%0d", it), pre, dly, rd, 1'b1, 1'b0);
      end
   endtask

   initial begin
      run_i = 1'b0; abort_i = 1'b0; smpl_i = 32'd0; smpl_vld_i = 1'b0; trg_i = 1'b0;
      read_cnt_i = 16'd0; delay_cnt_i = 16'd0; bus.tx_rdy_i = 1'b0;
      test_reset();
      test_basic();
      test_zero();
      test_clamp();
      test_stall();
      test_abort();
      test_reset_send();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/capture_ctrl.md
# capture_ctrl

Capture controller for the logIP sample path, directly upstream of the `mmu` sample RAM. It writes qualified samples into the `mmu` and watches for the trigger. After the trigger it counts the post-trigger delay, then reads the stored samples back newest-first. Read-back data goes to the transmitter over a valid/ready handshake.

## Interface
- `WIDTH`, 32, sample width; equals `mmu` `WIDTH`
- `DEPTH`, 5, `mmu` address width; capacity is 2**`DEPTH` samples
- `CNTW`, 16, width of the read and delay count inputs
- `clk_i` in 1: system clock
- `rst_in` in 1: reset, asynchronous, active-low
- `run_i` in 1: arm request, single-cycle pulse
- `abort_i` in 1: synchronous abort, returns the block to IDLE
- `smpl_i` in `WIDTH`: sample data
- `smpl_vld_i` in 1: sample strobe from the divider
- `trg_i` in 1: trigger hit, qualified by `smpl_vld_i`
- `read_cnt_i` in `CNTW`: number of samples to send
- `delay_cnt_i` in `CNTW`: samples written after the trigger sample
- `mem_wrt_o` out 1: write strobe to `mmu` `mem_wrt_i`
- `mem_read_o` out 1: read strobe to `mmu` `mem_read_i`
- `mem_o` out `WIDTH`: write data to `mmu` `mem_i`
- `mem_i` in `WIDTH`: read data from `mmu` `mem_o`
- `tx_data_o` out `WIDTH`: sample to the transmitter
- `tx_vld_o` out 1: `tx_data_o` valid
- `tx_rdy_i` in 1: transmitter accepts
- `busy_o` out 1: high in any state other than IDLE
- `done_o` out 1: one-cycle pulse when a capture completes

## Operation
- States: IDLE, ARMED, DELAY, ALIGN, READ, WAIT, SEND.
- IDLE:
  - `run_i` → ARMED.
  - Latch `read_cnt_i`, clamped to 2**`DEPTH`.
  - Latch `delay_cnt_i`.
- ARMED:
  - Every `smpl_vld_i` writes `smpl_i`.
  - `smpl_vld_i && trg_i` writes the trigger sample, then goes to DELAY.
  - If the latched delay is 0, go straight to ALIGN instead.
- DELAY:
  - Each `smpl_vld_i` writes one sample and decrements the delay counter.
  - The write that takes the counter to 0 → ALIGN.
- `mmu` pointer behaviour:
  - Ring of 2**`DEPTH` entries; the pointer wraps naturally on overflow.
  - Samples older than 2**`DEPTH` are overwritten.
  - The `mmu` writes at its pointer and then increments; it reads at its pointer and then decrements.
- ALIGN:
  - One `mem_read_o` pulse with data discarded; this moves the pointer onto the last written entry.
  - If the latched read count is 0 → IDLE with `done_o`; otherwise → READ.
- READ: one `mem_read_o` pulse → WAIT.
- WAIT: capture `mem_i` into `tx_data_o`, assert `tx_vld_o` → SEND.
- SEND:
  - Hold `tx_data_o` and `tx_vld_o` until `tx_rdy_i`.
  - On transfer, decrement the read counter.
  - If the counter is 0 → IDLE and pulse `done_o`; else → READ.
- Samples are sent newest first (trigger-relative order as the SUMP protocol expects).
- `run_i` outside IDLE is ignored. `trg_i` outside ARMED is ignored.
- `abort_i` in any state:
  - Next state is IDLE.
  - `mem_wrt_o`, `mem_read_o` and `tx_vld_o` drop the following cycle.
  - No `done_o`.
  - The `mmu` pointer is not restored.
- `abort_i` and `run_i` in the same cycle: abort wins.

## Timing
- Reset values (asynchronous, all outputs and state):
  - State = IDLE.
  - Counters = 0.
  - `mem_wrt_o`, `mem_read_o`, `tx_vld_o`, `busy_o`, `done_o` = 0.
  - `mem_o`, `tx_data_o` = 0.
- Reset mid-capture discards all progress; the `mmu` is reset by the same `rst_in`.
- Write path is registered:
  - `mem_wrt_o` and `mem_o` appear 1 cycle after `smpl_vld_i` / `smpl_i`.
  - `mem_wrt_o` is high exactly 1 cycle per sample.
- `mem_read_o` is a registered state decode, high 1 cycle per read.
- `mem_i` is valid the cycle after `mem_read_o` (`mmu` RAM latency 1).
- `tx_vld_o` rises 2 cycles after the `mem_read_o` pulse of its sample.
- Read-back throughput is at most 1 sample per 3 cycles.
- `done_o` is asserted in the cycle the state returns to IDLE.
- `busy_o` is registered: high from the cycle after `run_i` until that IDLE cycle.
- The write in flight when leaving DELAY completes before the ALIGN read; `mem_wrt_o` and `mem_read_o` are never high in the same cycle.

## Structure
- In `logIP_pkg`:
  - `capture_state_t` enum for the states.
  - `CAPTURE_CNTW_DEFAULT` constant.
- Sub-module `capture_cnt`:
  - Loadable `CNTW`-bit down-counter with a zero flag.
  - Instantiated twice: delay and read.
- The top level holds the FSM and the output registers; the `mmu` is instantiated by the parent.

## Test plan
- `delay_cnt_i`=2, `read_cnt_i`=4, samples 1,2,3,… with `trg_i` on sample 5 → writes stop after sample 7; `tx_data_o` sequence is 7,6,5,4; one `done_o` pulse.
- `delay_cnt_i`=0, `read_cnt_i`=0, trigger on the first sample → exactly one ALIGN read, zero transfers, `done_o` 3 cycles after the trigger write.
- `DEPTH`=5, 40 samples before the trigger, `read_cnt_i`=40 → count clamps to 32; 32 transfers, newest first; pointer wrap is seamless.
- `tx_rdy_i` held low for 10 cycles during SEND → `tx_data_o` stable and `tx_vld_o` high throughout; no extra `mem_read_o`.
- `abort_i` in DELAY → IDLE the next cycle, `busy_o`=0, no `done_o`, no reads; a following `run_i` re-arms.
- `rst_in` asserted in SEND → all outputs 0 asynchronously; state IDLE after release.
